lfsr_4bit: RTL and testbench



---
 rtl/lfsr_4bit.sv | 47 ++++
 tb/tb_lfsr_4bit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_4bit.sv
// lfsr_4bit: free-running 4-bit maximal-length Fibonacci LFSR (x^4 + x^3 + 1).
// It provides the raw state, a serial output bit, and a 4-bit word built from
// the last four serial bits. It also recovers by itself from the all-zero
// lock-up state. It is meant for scrambling, test patterns and dither, and is
// not a cryptographic source.
module lfsr_4bit #(
    parameter logic [3:0] SEED = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] lfsr,
    output logic [3:0] random_num,
    output logic       output_bit
);

    // An all-zero seed would lock the register, so it is replaced by 0001.
    localparam logic [3:0] EFFECTIVE_SEED = (SEED == 4'b0000) ? 4'b0001 : SEED;

    logic       feedback;
    logic [3:0] next_lfsr;

    // Next state: shift left with the tap XOR entering bit 0. An all-zero
    // state (only reachable through an upset) reloads the seed instead.
    always_comb begin
        feedback  = lfsr[3] ^ lfsr[2];
        next_lfsr = {lfsr[2:0], feedback};
        if (lfsr == 4'b0000) begin
            next_lfsr = EFFECTIVE_SEED;
        end
    end

    // State and word registers. The word collects the bit being shifted out,
    // so its MSB is the oldest bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= EFFECTIVE_SEED;
            random_num <= 4'b0000;
        end else begin
            lfsr       <= next_lfsr;
            random_num <= {random_num[2:0], lfsr[3]};
        end
    end

    // The serial bit is the MSB that the next edge shifts out.
    assign output_bit = lfsr[3];

endmodule

// File: tb/tb_lfsr_4bit.sv
// tb_lfsr_4bit: self-checking bench for lfsr_4bit. It runs three instances
// (default seed, seed 1000, illegal seed 0000) against a table-driven
// reference model.
module tb_lfsr_4bit;

    logic clk;
    logic rst;

    logic [3:0] lfsr_d, word_d;
    logic       bit_d;
    logic [3:0] lfsr_s8, word_s8;
    logic       bit_s8;
    logic [3:0] lfsr_s0, word_s0;
    logic       bit_s0;

    int tests_run;
    int tests_failed;

    // The published maximal-length sequence starting from 0001.
    logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                             4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                             4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Model state per instance: a position in the sequence table and a
    // history of the bits shifted out.
    int         idx       [3];
    int         start_idx [3] = '{0, 14, 0};
    logic [3:0] hist      [3];

    lfsr_4bit u_dut (
        .clk        (clk),
        .rst        (rst),
        .lfsr       (lfsr_d),
        .random_num (word_d),
        .output_bit (bit_d)
    );

    lfsr_4bit #(.SEED(4'b1000)) u_dut_s8 (
        .clk        (clk),
        .rst        (rst),
        .lfsr       (lfsr_s8),
        .random_num (word_s8),
        .output_bit (bit_s8)
    );

    lfsr_4bit #(.SEED(4'b0000)) u_dut_s0 (
        .clk        (clk),
        .rst        (rst),
        .lfsr       (lfsr_s0),
        .random_num (word_s0),
        .output_bit (bit_s0)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drives rst for one edge, then samples 1 ns later and advances the model.
    task automatic applyStimulus(input logic rst_val);
        rst = rst_val;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst_val) begin
                hist[i] = 4'b0000;
                idx[i]  = start_idx[i];
            end else begin
                hist[i] = {hist[i][2:0], seq[idx[i]][3]};
                idx[i]  = (idx[i] + 1) % 15;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".lfsr"},     lfsr_d,          seq[idx[0]]);
        checkValue({tag, ".word"},     word_d,          hist[0]);
        checkValue({tag, ".bit"},      {3'b000, bit_d}, {3'b000, seq[idx[0]][3]});
        checkValue({tag, ".s8.lfsr"},  lfsr_s8,         seq[idx[1]]);
        checkValue({tag, ".s8.word"},  word_s8,         hist[1]);
        checkValue({tag, ".s8.bit"},   {3'b000, bit_s8}, {3'b000, seq[idx[1]][3]});
        checkValue({tag, ".s0.lfsr"},  lfsr_s0,         seq[idx[2]]);
        checkValue({tag, ".s0.word"},  word_s0,         hist[2]);
    endtask

    // Directed sequence followed by a randomized reset phase.
    initial begin
        logic [3:0] expected_words [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001,
                                           4'b0010, 4'b0100, 4'b1001, 4'b0011};
        logic [15:0] seen;
        int steps;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idx[i]  = start_idx[i];
            hist[i] = 4'b0000;
        end

        // Reset held high for two edges.
        for (int e = 0; e < 2; e++) begin
            applyStimulus(1'b1);
            checkValue("reset.lfsr", lfsr_d, 4'b0001);
            checkValue("reset.word", word_d, 4'b0000);
            checkValue("reset.bit", {3'b000, bit_d}, 4'b0000);
            checkValue("reset.s8.lfsr", lfsr_s8, 4'b1000);
            checkValue("reset.s8.bit", {3'b000, bit_s8}, 4'b0001);
            checkValue("reset.s0.lfsr", lfsr_s0, 4'b0001);
            checkOutput("reset");
        end

        // Free run for 35 edges.
        seen = '0;
        for (int e = 1; e <= 35; e++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("run%0d", e));
            if (e <= 15) seen[lfsr_d] = 1'b1;
            if (e <= 8) checkValue($sformatf("word%0d", e), word_d, expected_words[e-1]);
            if (e == 1)  checkValue("edge1",  lfsr_d, 4'b0010);
            if (e == 15) checkValue("edge15", lfsr_d, 4'b0001);
            if (e == 16) checkValue("edge16", lfsr_d, 4'b0010);
            if (e == 30) checkValue("edge30", lfsr_d, 4'b0001);
            if (e == 1)  checkValue("s8.first", lfsr_s8, 4'b0001);
        end
        checkValue("period.all_nonzero", {3'b000, &seen[15:1]}, 4'b0001);
        checkValue("period.no_zero", {3'b000, seen[0]}, 4'b0000);

        // Run to state 1101, then assert reset for one edge.
        steps = 0;
        while (seq[idx[0]] != 4'b1101 && steps < 20) begin
            applyStimulus(1'b0);
            steps++;
        end
        checkValue("midrst.pre", lfsr_d, 4'b1101);
        applyStimulus(1'b1);
        checkValue("midrst.lfsr", lfsr_d, 4'b0001);
        checkValue("midrst.word", word_d, 4'b0000);
        applyStimulus(1'b0);
        checkValue("midrst.restart", lfsr_d, 4'b0010);
        checkOutput("midrst");

        // Lock-up: force the default instance's state to zero between edges.
        for (int e = 0; e < 3; e++) applyStimulus(1'b0);
        @(negedge clk);
        force u_dut.lfsr = 4'b0000;
        #1;
        checkValue("lockup.forced_bit", {3'b000, bit_d}, 4'b0000);
        release u_dut.lfsr;
        rst = 1'b0;
        @(posedge clk);
        #1;
        hist[0] = {hist[0][2:0], 1'b0};
        idx[0]  = start_idx[0];
        for (int i = 1; i < 3; i++) begin
            hist[i] = {hist[i][2:0], seq[idx[i]][3]};
            idx[i]  = (idx[i] + 1) % 15;
        end
        checkValue("lockup.lfsr", lfsr_d, 4'b0001);
        checkOutput("lockup");

        // Randomized reset pulses with free running between them.
        for (int e = 0; e < 200; e++) begin
            applyStimulus(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            checkOutput($sformatf("rand%0d", e));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
